// File: rtl/ap3_alu_pkg.sv
// Shared types and sizing helpers for the AP3 wide-add scheduler.
// No logic; state encoding plus compile-time width functions.
package ap3_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/ap3_alu_slice.sv
// CHUNK-bit add/subtract slice kept as a plain '+' so it lands on the carry chain.
// Latency: combinational.
// Backpressure: none.
module ap3_alu_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bi,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;

  assign b_eff = bi ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, ci};
  assign s     = sum[CHUNK-1:0];
  assign co    = sum[CHUNK];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry into it falls out by XOR.
  assign cmsb  = sum[CHUNK-1] ^ a[CHUNK-1] ^ b_eff[CHUNK-1];

endmodule

// File: rtl/ap3_alu_sched.sv
// Round-robin scheduler feeding wide add/sub ops through one CHUNK-bit slice, LSB first.
// Latency: rsp_valid NCHUNK+1 cycles after the accept cycle.
// Backpressure: holds the result in DONE until rsp_ready; req_ready is low outside IDLE.
module ap3_alu_sched
  import ap3_alu_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 8,
  localparam int IDW   = idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_co,
  output logic                  rsp_ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW     = idw(NCHUNK);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     cand;
  logic [WIDTH-1:0] gnt_a, gnt_b;
  logic             gnt_sub;

  logic [CHUNK-1:0] sl_a, sl_b, sl_s;
  logic             sl_co, sl_cmsb;

  // Scan from ptr+1 upward with wrap; the extra cand bit absorbs the wrap before the subtract.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i) + (IDW+1)'(1);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!gnt_vld && req_valid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    gnt_a     = '0;
    gnt_b     = '0;
    gnt_sub   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_idx == IDW'(j)) begin
        gnt_a   = req_a[j*WIDTH +: WIDTH];
        gnt_b   = req_b[j*WIDTH +: WIDTH];
        gnt_sub = req_sub[j];
        if (state_q == IDLE && gnt_vld) begin
          req_ready[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        sl_a = a_q[i*CHUNK +: CHUNK];
        sl_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  ap3_alu_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .bi   (sub_q),
    .ci   (carry_q),
    .s    (sl_s),
    .co   (sl_co),
    .cmsb (sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    k_d     = k_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = RUN;
          ptr_d   = gnt_idx;
          id_d    = gnt_idx;
          a_d     = gnt_a;
          b_d     = gnt_b;
          sub_d   = gnt_sub;
          carry_d = gnt_sub;
          k_d     = '0;
        end
      end
      RUN: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (k_q == KW'(i)) begin
            y_d[i*CHUNK +: CHUNK] = sl_s;
          end
        end
        carry_d = sl_co;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NCHUNK-1)) begin
          co_d    = sl_co;
          ovf_d   = sl_cmsb ^ sl_co;
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ-1);
      id_q    <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;
  assign rsp_co    = co_q;
  assign rsp_ovf   = ovf_q;

endmodule
